addsub_serial: RTL and testbench
================================

ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a new operation; sampled on rising clk.
REQ-005 m  input  1  mode: 0 = add, 1 = subtract.
REQ-006 cin  input  1  carry-in for add, borrow-in for subtract.
REQ-007 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 b  input  WIDTH  operand B, unsigned or two's complement.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse when result, cout and ovf are valid.
REQ-011 result  output  WIDTH  sum or difference.
REQ-012 cout  output  1  carry-out in add mode, borrow-out in subtract mode.
REQ-013 ovf  output  1  signed (two's complement) overflow flag.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 Transitions SHALL be: IDLE->RUN on start; RUN->DONE after exactly WIDTH RUN cycles; DONE->RUN on start; DONE->IDLE otherwise.
REQ-016 start SHALL be accepted only in IDLE or DONE, and SHALL be ignored in RUN without disturbing the operation in flight.
REQ-017 On acceptance, the block SHALL latch a, b XOR {WIDTH{m}}, m, an internal carry of (cin XOR m), and SHALL clear the bit counter.
REQ-018 Later changes to a, b, m and cin SHALL NOT affect the operation in flight.
REQ-019 Each RUN cycle SHALL perform one full-add on bit i, LSB first: s = a_i ^ b'_i ^ c; c_next = a_i&b'_i | (a_i^b'_i)&c.
REQ-020 After each RUN cycle, s SHALL be shifted into the working register and the counter SHALL increment.
REQ-021 Latency: done SHALL assert WIDTH+1 cycles after the accepting edge, and busy SHALL be high exactly for the WIDTH RUN cycles.
REQ-022 On the RUN->DONE edge, result SHALL load the full WIDTH-bit value.
REQ-023 On the same edge, cout SHALL load the final carry if m=0, or its inverse (borrow) if m=1.
REQ-024 result, cout and ovf SHALL hold their values from the done pulse until the next RUN->DONE edge, including during a following RUN.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH: add gives A+B+cin; subtract gives A-B-cin.
REQ-026 done SHALL be high only in DONE, for exactly one cycle per accepted start.
REQ-027 start held high continuously SHALL give back-to-back operations with period WIDTH+1 cycles.

Reset
REQ-028 While rst is high, the FSM SHALL be in IDLE, and busy, done, result, cout, ovf, the counter and all internal registers SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL abort the operation at once, SHALL NOT produce a done pulse, and SHALL discard the partial result.
REQ-030 The first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-031 Macro ADDSUB_OVF_DETECT_EN defined: ovf SHALL load, at the RUN->DONE edge, carry-into-MSB XOR carry-out-of-MSB of the internal (non-inverted) carry chain.
REQ-032 Macro ADDSUB_OVF_DETECT_EN undefined: ovf SHALL be constant 0, no MSB-carry register SHALL exist, and all other behaviour SHALL be identical.

Verification (WIDTH=8, ADDSUB_OVF_DETECT_EN defined unless stated)
REQ-033 Add: a=0x35, b=0x4A, m=0, cin=0, start 1 cycle -> busy 8 cycles; done at cycle 9; result=0x7F, cout=0, ovf=0.
REQ-034 Signed overflow: a=0x7F, b=0x01, m=0, cin=0 -> result=0x80, cout=0, ovf=1. With macro undefined -> ovf=0, result/cout unchanged.
REQ-035 Subtract: a=0x10, b=0x20, m=1, cin=0 -> result=0xF0, cout(borrow)=1, ovf=0. Same with cin=1 -> result=0xEF, cout=1.
REQ-036 Full carry: a=0xFF, b=0xFF, m=0, cin=1 -> result=0xFF, cout=1, ovf=0. Then start again with a=0x01, b=0x01 in the DONE cycle -> back-to-back accepted; result=0x02 nine cycles later.
REQ-037 Start in RUN: start pulsed at RUN cycle 3 with different operands -> ignored; one done only, carrying the original result.
REQ-038 Reset mid-op: rst asserted at RUN cycle 4 -> all outputs 0 immediately, no done; next start completes correctly.

Source files
------------

// File: rtl/addsub_serial.sv
`default_nettype none
// ============================================================================
// Module      : addsub_serial
// Description : Bit-serial (LSB-first) add/subtract unit, one bit per clock.
//               Optional macro ADDSUB_OVF_DETECT_EN enables the signed
//               overflow flag; otherwise o_ovf is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_m,
    input  logic             i_cin,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_m;
    logic               r_c;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout;

    logic               w_ai;
    logic               w_bi;
    logic               w_sum;
    logic               w_cnext;
    logic [WIDTH-1:0]   w_work_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = RUN;
                    w_accept    = 1'b1;
                end
            end
            RUN: begin
                if (r_cnt == c_last_bit) begin
                    w_state_nxt = DONE;
                    w_last      = 1'b1;
                end
            end
            DONE: begin
                if (i_start) begin
                    w_state_nxt = RUN;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // One full-adder slice; b is pre-inverted and carry pre-set for subtract.
    always_comb begin
        w_ai                = r_a[r_cnt];
        w_bi                = r_b[r_cnt];
        w_sum               = w_ai ^ w_bi ^ r_c;
        w_cnext             = (w_ai & w_bi) | ((w_ai ^ w_bi) & r_c);
        w_work_nxt          = r_work;
        w_work_nxt[r_cnt]   = w_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_m      <= 1'b0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_work   <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a    <= i_a;
                r_b    <= i_b ^ {WIDTH{i_m}};
                r_m    <= i_m;
                r_c    <= i_cin ^ i_m;
                r_cnt  <= '0;
                r_work <= '0;
            end else if (r_state == RUN) begin
                r_c    <= w_cnext;
                r_work <= w_work_nxt;
                r_cnt  <= r_cnt + 1'b1;
                if (w_last) begin
                    r_result <= w_work_nxt;
                    r_cout   <= w_cnext ^ r_m;
                end
            end
        end
    end

`ifdef ADDSUB_OVF_DETECT_EN
    logic r_ovf;

    // During the last RUN cycle r_c is the carry into the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_ovf <= r_c ^ w_cnext;
        end
    end

    assign o_ovf = r_ovf;
`else
    assign o_ovf = 1'b0;
`endif

    assign o_busy   = (r_state == RUN);
    assign o_done   = (r_state == DONE);
    assign o_result = r_result;
    assign o_cout   = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_addsub_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_serial
// Description : Directed self-checking bench for addsub_serial (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_serial;

`ifdef ADDSUB_OVF_DETECT_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       m = 1'b0;
    logic       cin = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       cout;
    logic       ovf;

    int n_checks = 0;
    int n_pass   = 0;

    addsub_serial #(.WIDTH(8)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (start),
        .i_m      (m),
        .i_cin    (cin),
        .i_a      (a),
        .i_b      (b),
        .o_busy   (busy),
        .o_done   (done),
        .o_result (result),
        .o_cout   (cout),
        .o_ovf    (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vm;
        logic       vc;
        logic [7:0] er;
        logic       eco;
        logic       eov;
    } vec_t;

    // Called at a negedge; returns at the negedge after the accepting edge
    // with the operand inputs scrambled.
    task automatic launch(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic tm, input logic tc);
        a = ta; b = tb_v; m = tm; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = 8'h5A; m = ~tm; cin = ~tc;
    endtask

    task automatic wait_done(output int busy_cnt, output int done_cyc);
        busy_cnt = 0;
        done_cyc = 0;
        for (int n = 1; n <= 20; n++) begin
            if (n > 1) @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cyc = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done got %b exp 0", done); else n_pass++;
        n_checks++; if (result !== 8'h00) $display("FAIL rst_result got %h exp 00", result); else n_pass++;
        n_checks++; if (cout !== 1'b0) $display("FAIL rst_cout got %b exp 0", cout); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL rst_ovf got %b exp 0", ovf); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_arith();
        vec_t tbl[4];
        int   bc, dc;
        tbl[0] = '{8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0};
        tbl[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, OVF_EN};
        tbl[2] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b1, 1'b0};
        tbl[3] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hEF, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            launch(tbl[i].va, tbl[i].vb, tbl[i].vm, tbl[i].vc);
            wait_done(bc, dc);
            n_checks++; if (bc !== 8) $display("FAIL arith%0d_busy_cycles got %0d exp 8", i, bc); else n_pass++;
            n_checks++; if (dc !== 9) $display("FAIL arith%0d_done_cycle got %0d exp 9", i, dc); else n_pass++;
            n_checks++; if (result !== tbl[i].er) $display("FAIL arith%0d_result got %h exp %h", i, result, tbl[i].er); else n_pass++;
            n_checks++; if (cout !== tbl[i].eco) $display("FAIL arith%0d_cout got %b exp %b", i, cout, tbl[i].eco); else n_pass++;
            n_checks++; if (ovf !== tbl[i].eov) $display("FAIL arith%0d_ovf got %b exp %b", i, ovf, tbl[i].eov); else n_pass++;
            @(negedge clk);
            n_checks++; if (done !== 1'b0) $display("FAIL arith%0d_done_pulse got %b exp 0", i, done); else n_pass++;
            n_checks++; if (result !== tbl[i].er) $display("FAIL arith%0d_hold got %h exp %h", i, result, tbl[i].er); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int bc, dc;
        launch(8'hFF, 8'hFF, 1'b0, 1'b1);
        wait_done(bc, dc);
        n_checks++; if (dc !== 9) $display("FAIL b2b_first_done got %0d exp 9", dc); else n_pass++;
        n_checks++; if (result !== 8'hFF) $display("FAIL b2b_first_result got %h exp ff", result); else n_pass++;
        n_checks++; if (cout !== 1'b1) $display("FAIL b2b_first_cout got %b exp 1", cout); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL b2b_first_ovf got %b exp 0", ovf); else n_pass++;
        launch(8'h01, 8'h01, 1'b0, 1'b0);
        n_checks++; if (busy !== 1'b1) $display("FAIL b2b_accept_busy got %b exp 1", busy); else n_pass++;
        n_checks++; if (result !== 8'hFF) $display("FAIL b2b_hold_in_run got %h exp ff", result); else n_pass++;
        n_checks++; if (cout !== 1'b1) $display("FAIL b2b_cout_hold got %b exp 1", cout); else n_pass++;
        wait_done(bc, dc);
        n_checks++; if (dc !== 9) $display("FAIL b2b_second_done got %0d exp 9", dc); else n_pass++;
        n_checks++; if (result !== 8'h02) $display("FAIL b2b_second_result got %h exp 02", result); else n_pass++;
        n_checks++; if (cout !== 1'b0) $display("FAIL b2b_second_cout got %b exp 0", cout); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_start_held();
        int d1 = 0;
        int d2 = 0;
        a = 8'h03; b = 8'h04; m = 1'b0; cin = 1'b0; start = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (d1 == 0) d1 = n;
                else if (d2 == 0) d2 = n;
            end
            if (n == 10) start = 1'b0;
        end
        n_checks++; if (d1 !== 9) $display("FAIL held_first_done got %0d exp 9", d1); else n_pass++;
        n_checks++; if (d2 !== 18) $display("FAIL held_second_done got %0d exp 18", d2); else n_pass++;
        n_checks++; if (result !== 8'h07) $display("FAIL held_result got %h exp 07", result); else n_pass++;
    endtask

    task automatic test_start_in_run();
        int         ndone = 0;
        int         dcyc  = 0;
        logic [7:0] dres  = 8'h00;
        launch(8'h12, 8'h34, 1'b0, 1'b0);
        for (int n = 1; n <= 20; n++) begin
            if (n > 1) @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (dcyc == 0) begin
                    dcyc = n;
                    dres = result;
                end
            end
            if (n == 3) begin
                start = 1'b1; a = 8'hAA; b = 8'h55; m = 1'b1;
            end
            if (n == 4) start = 1'b0;
        end
        n_checks++; if (ndone !== 1) $display("FAIL run_start_done_count got %0d exp 1", ndone); else n_pass++;
        n_checks++; if (dcyc !== 9) $display("FAIL run_start_done_cycle got %0d exp 9", dcyc); else n_pass++;
        n_checks++; if (dres !== 8'h46) $display("FAIL run_start_result got %h exp 46", dres); else n_pass++;
    endtask

    task automatic test_reset_midop();
        int bc, dc;
        int ndone = 0;
        launch(8'h35, 8'h4A, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL midrst_done got %b exp 0", done); else n_pass++;
        n_checks++; if (result !== 8'h00) $display("FAIL midrst_result got %h exp 00", result); else n_pass++;
        n_checks++; if (cout !== 1'b0) $display("FAIL midrst_cout got %b exp 0", cout); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL midrst_ovf got %b exp 0", ovf); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        n_checks++; if (ndone !== 0) $display("FAIL midrst_no_done got %0d exp 0", ndone); else n_pass++;
        launch(8'h35, 8'h4A, 1'b0, 1'b0);
        wait_done(bc, dc);
        n_checks++; if (dc !== 9) $display("FAIL midrst_next_done got %0d exp 9", dc); else n_pass++;
        n_checks++; if (result !== 8'h7F) $display("FAIL midrst_next_result got %h exp 7f", result); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_start_held();
        test_start_in_run();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached before summary");
        $fatal(1);
    end

endmodule
`default_nettype wire
